// File: rtl/linebuffer_reader.sv
// rtl/linebuffer_reader.sv - streams completed lines out of a BRAM line ring
//
// Purpose: counts lines the writer has finished, issues BRAM reads pixel by
// pixel through the ring of line slots, and forwards the read data through a
// 4-entry skid FIFO onto a valid/ready pixel stream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   line_wr_done          writer pulse: one more complete line is in the ring
//   bram_en/bram_addr     registered read request; bram_rdata valid next cycle
//   m_valid/m_ready       output stream handshake
//   m_data/m_last         head pixel word, last-pixel-of-line marker
//   line_rd_done          one-cycle pulse after a line's last pixel is taken
//   ovf_err               sticky: a line_wr_done arrived with the ring full
module linebuffer_reader #(
  parameter int DWIDTH    = 8,
  parameter int P_CH      = 32,
  parameter int IMG_W     = 64,
  parameter int NUM_LINES = 4,
  localparam int WORD_W   = DWIDTH * P_CH,
  localparam int ADDR_W   = $clog2(NUM_LINES * IMG_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_wr_done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [WORD_W-1:0] bram_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              line_rd_done,
  output logic              ovf_err
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int SLOT_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int AV_W   = $clog2(NUM_LINES + 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t              state_q, state_d;
  logic [AV_W-1:0]     avail_q, avail_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                bram_en_q, bram_last_q;
  logic [ADDR_W-1:0]   bram_addr_q;
  logic                rd_valid_q, rd_last_q;
  logic [WORD_W-1:0]   mem_data_q [4];
  logic                mem_last_q [4];
  logic [1:0]          wr_ptr_q, rd_ptr_q;
  logic [2:0]          fifo_count_q;
  logic                line_rd_done_q, ovf_q;

  logic                issue, last_col, dec, inc, full, ovf_set, push, pop;
  logic [2:0]          occ;
  logic [ADDR_W-1:0]   addr_next;

  // Occupancy counts FIFO entries plus both read pipeline stages; a same-cycle
  // pop is deliberately ignored so the FIFO can never be overrun.
  assign occ       = fifo_count_q + 3'(bram_en_q) + 3'(rd_valid_q);
  assign last_col  = (col_q == COL_W'(IMG_W - 1));
  assign full      = (avail_q == AV_W'(NUM_LINES));
  assign dec       = issue && last_col;
  assign inc       = line_wr_done && (!full || dec);
  assign ovf_set   = line_wr_done && full && !dec;
  assign addr_next = ADDR_W'(32'(slot_q) * IMG_W + 32'(col_q));
  assign push      = rd_valid_q;
  assign pop       = m_valid && m_ready;

  always_comb begin
    avail_d = avail_q;
    case ({inc, dec})
      2'b10:   avail_d = avail_q + AV_W'(1);
      2'b01:   avail_d = avail_q - AV_W'(1);
      default: avail_d = avail_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state follows avail_d so READ coincides with avail_q > 0; this keeps
  // the first issue on the edge right after the first line_wr_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (avail_d != '0) state_d = S_READ;
      S_READ:  if (dec && avail_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: read issue.
  always_comb begin
    issue = 1'b0;
    if (state_q == S_READ && occ < 3'd4) issue = 1'b1;
  end

  always_comb begin
    slot_d = slot_q;
    col_d  = col_q;
    if (issue) begin
      if (last_col) begin
        col_d  = '0;
        slot_d = (slot_q == SLOT_W'(NUM_LINES - 1)) ? '0 : slot_q + SLOT_W'(1);
      end else begin
        col_d  = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_q        <= '0;
      slot_q         <= '0;
      col_q          <= '0;
      bram_en_q      <= 1'b0;
      bram_addr_q    <= '0;
      bram_last_q    <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_count_q   <= '0;
      line_rd_done_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      avail_q    <= avail_d;
      slot_q     <= slot_d;
      col_q      <= col_d;
      bram_en_q  <= issue;
      if (issue) begin
        bram_addr_q <= addr_next;
        bram_last_q <= last_col;
      end
      // Tag travels alongside the BRAM read latency.
      rd_valid_q <= bram_en_q;
      rd_last_q  <= bram_last_q;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 3'd1;
        2'b01:   fifo_count_q <= fifo_count_q - 3'd1;
        default: fifo_count_q <= fifo_count_q;
      endcase
      line_rd_done_q <= pop && mem_last_q[rd_ptr_q];
      ovf_q          <= ovf_q | ovf_set;
    end
  end

  // FIFO storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bram_rdata;
      mem_last_q[wr_ptr_q] <= rd_last_q;
    end
  end

  assign bram_en      = bram_en_q;
  assign bram_addr    = bram_addr_q;
  assign m_valid      = (fifo_count_q != '0);
  assign m_data       = m_valid ? mem_data_q[rd_ptr_q] : '0;
  assign m_last       = m_valid && mem_last_q[rd_ptr_q];
  assign line_rd_done = line_rd_done_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_linebuffer_reader.sv
// tb/tb_linebuffer_reader.sv - scoreboard bench for linebuffer_reader
module tb_linebuffer_reader;
  localparam int DWIDTH = 8, P_CH = 32, IMG_W = 64, NUM_LINES = 4;
  localparam int WORD_W = DWIDTH * P_CH;
  localparam int ADDR_W = $clog2(NUM_LINES * IMG_W);
  localparam int RING   = NUM_LINES * IMG_W;

  logic              clk = 1'b0, rst_n = 1'b1, line_wr_done = 1'b0, m_ready = 1'b0;
  logic              bram_en, m_valid, m_last, line_rd_done, ovf_err;
  logic [ADDR_W-1:0] bram_addr;
  logic [WORD_W-1:0] bram_rdata = '0, m_data;

  linebuffer_reader #(.DWIDTH(DWIDTH), .P_CH(P_CH), .IMG_W(IMG_W), .NUM_LINES(NUM_LINES)) dut (
    .clk(clk), .rst_n(rst_n), .line_wr_done(line_wr_done),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .line_rd_done(line_rd_done), .ovf_err(ovf_err));

  always #5 clk = ~clk;

  typedef struct packed {logic [WORD_W-1:0] data; logic last;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_checks = 0, n_pass = 0;
  int tb_slot = 0, addr_exp = 0, occ = 0, xfers = 0, rd_dones = 0;
  bit prev_stall = 0, prev_last_xfer = 0;
  logic [WORD_W-1:0] prev_data = '0;

  function automatic logic [WORD_W-1:0] pix(input int a);
    logic [WORD_W-1:0] w;
    for (int i = 0; i < P_CH; i++) w[i*DWIDTH +: DWIDTH] = 8'(a) ^ 8'(i * 37);
    return w;
  endfunction

  task automatic check(input string name, input bit ok, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // BRAM model: contents are a pure function of address.
  always @(posedge clk) if (bram_en) bram_rdata <= pix(int'(bram_addr));

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0; occ = 0; prev_last_xfer = 0;
    end else begin
      if (prev_stall) check("stall_hold", m_valid && m_data == prev_data, m_data, prev_data);
      if (bram_en) begin
        occ++;
        check("bram_addr", int'(bram_addr) == addr_exp, WORD_W'(bram_addr), WORD_W'(addr_exp));
        check("occupancy", occ <= 4, WORD_W'(occ), WORD_W'(4));
        addr_exp = (addr_exp + 1) % RING;
      end
      if (line_rd_done || prev_last_xfer)
        check("line_rd_done", line_rd_done == prev_last_xfer, WORD_W'(line_rd_done), WORD_W'(prev_last_xfer));
      if (line_rd_done) rd_dones++;
      prev_last_xfer = 0;
      if (m_valid && m_ready) begin
        occ--; xfers++;
        if (exp_q.size() == 0) check("unexpected_pixel", 0, m_data, '0);
        else begin
          e = exp_q.pop_front();
          check("pix_data", m_data == e.data, m_data, e.data);
          check("pix_last", m_last == e.last, WORD_W'(m_last), WORD_W'(e.last));
        end
        prev_last_xfer = m_last;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic push_line();
    for (int c = 0; c < IMG_W; c++) exp_q.push_back('{pix(tb_slot * IMG_W + c), c == IMG_W - 1});
    tb_slot = (tb_slot + 1) % NUM_LINES;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; line_wr_done = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete(); tb_slot = 0; addr_exp = 0;
    #1 rst_n = 1'b1;
  endtask

  // Drives line_wr_done high for n consecutive sampling edges.
  task automatic pulses(input int n);
    @(posedge clk); #1 line_wr_done = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    line_wr_done = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    check(name, exp_q.size() == 0, WORD_W'(exp_q.size()), '0);
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!m_valid && n < 50) begin @(negedge clk); n++; end
    check(name, m_valid, WORD_W'(m_valid), WORD_W'(1));
  endtask

  initial begin
    int rd0, x0, gaps, n;
    #1 rst_n = 1'b0;
    #1;
    check("reset_m_valid", m_valid == 0, WORD_W'(m_valid), '0);
    check("reset_m_data", m_data == '0, m_data, '0);
    check("reset_misc", {m_last, bram_en, line_rd_done, ovf_err} == 4'b0,
          WORD_W'({m_last, bram_en, line_rd_done, ovf_err}), '0);
    check("reset_bram_addr", bram_addr == '0, WORD_W'(bram_addr), '0);
    do_reset();

    // One line, m_ready high: latency, no bubbles, one line_rd_done.
    m_ready = 1'b1; rd0 = rd_dones;
    @(posedge clk); #1 line_wr_done = 1'b1; push_line();
    @(posedge clk); #1 line_wr_done = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("t026_valid_e2", m_valid == 0, WORD_W'(m_valid), '0);
    @(posedge clk); @(negedge clk);
    check("t026_valid_e3", m_valid == 1, WORD_W'(m_valid), WORD_W'(1));
    gaps = 0;
    repeat (IMG_W - 1) begin @(negedge clk); if (!m_valid) gaps++; end
    check("t026_bubbles", gaps == 0, WORD_W'(gaps), '0);
    wait_drain("t026_drain", 200);
    check("t026_rd_done", rd_dones - rd0 == 1, WORD_W'(rd_dones - rd0), WORD_W'(1));

    // Four lines back to back.
    do_reset(); m_ready = 1'b1; rd0 = rd_dones;
    repeat (4) push_line();
    pulses(4);
    wait_valid("t027_start");
    gaps = 0;
    repeat (RING) begin if (!m_valid) gaps++; @(negedge clk); end
    check("t027_bubbles", gaps == 0, WORD_W'(gaps), '0);
    wait_drain("t027_drain", 400);
    check("t027_rd_done", rd_dones - rd0 == 4, WORD_W'(rd_dones - rd0), WORD_W'(4));
    check("t027_no_ovf", ovf_err == 0, WORD_W'(ovf_err), '0);

    // Three lines with random back-pressure.
    do_reset(); rd0 = rd_dones;
    repeat (3) push_line();
    pulses(3);
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    m_ready = 1'b1;
    wait_drain("t028_drain", 50);
    check("t028_rd_done", rd_dones - rd0 == 3, WORD_W'(rd_dones - rd0), WORD_W'(3));

    // Five lines while stalled: fifth dropped, overflow sticky.
    do_reset(); m_ready = 1'b0;
    repeat (4) push_line();
    pulses(5);
    repeat (5) @(posedge clk); #1;
    check("t029_ovf", ovf_err == 1, WORD_W'(ovf_err), WORD_W'(1));
    check("t029_valid_stalled", m_valid == 1, WORD_W'(m_valid), WORD_W'(1));
    x0 = xfers; m_ready = 1'b1;
    wait_drain("t029_drain", 600);
    repeat (10) @(posedge clk); #1;
    check("t029_count", xfers - x0 == RING, WORD_W'(xfers - x0), WORD_W'(RING));
    check("t029_ovf_sticky", ovf_err == 1, WORD_W'(ovf_err), WORD_W'(1));
    check("t029_empty", m_valid == 0, WORD_W'(m_valid), '0);

    // line_wr_done coincides with the column-63 issue.
    do_reset(); m_ready = 1'b1; rd0 = rd_dones;
    push_line();
    pulses(1);
    n = 0;
    while (!(bram_en && bram_addr == ADDR_W'(IMG_W - 2)) && n < 200) begin @(negedge clk); n++; end
    check("t030_find_col62", bram_en && bram_addr == ADDR_W'(IMG_W - 2), WORD_W'(bram_addr), WORD_W'(IMG_W - 2));
    line_wr_done = 1'b1; push_line();
    @(posedge clk); #1 line_wr_done = 1'b0;
    gaps = 0; n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
      if (!m_valid && exp_q.size() != 0) gaps++;
    end
    check("t030_bubbles", gaps == 0, WORD_W'(gaps), '0);
    wait_drain("t030_drain", 50);
    gaps = 0;
    repeat (10) begin @(negedge clk); if (m_valid || bram_en) gaps++; end
    check("t030_idle", gaps == 0, WORD_W'(gaps), '0);
    check("t030_rd_done", rd_dones - rd0 == 2, WORD_W'(rd_dones - rd0), WORD_W'(2));

    // Reset at pixel 20.
    do_reset(); m_ready = 1'b1; x0 = xfers;
    push_line();
    pulses(1);
    n = 0;
    while (xfers - x0 < 20 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("t031_zero", {m_valid, m_last, bram_en, line_rd_done, ovf_err} == 5'b0 && m_data == '0 && bram_addr == '0,
          WORD_W'({m_valid, m_last, bram_en, line_rd_done, ovf_err}), '0);
    exp_q.delete(); tb_slot = 0; addr_exp = 0;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    gaps = 0;
    repeat (10) begin @(negedge clk); if (m_valid || bram_en) gaps++; end
    check("t031_quiet", gaps == 0, WORD_W'(gaps), '0);
    push_line();
    pulses(1);
    n = 0;
    while (!bram_en && n < 20) begin @(negedge clk); n++; end
    check("t031_first_addr", bram_en && bram_addr == '0, WORD_W'(bram_addr), '0);
    wait_drain("t031_drain", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
